sign_to_double_seq: RTL and testbench
=====================================

// Module: sigN_to_double_seq
// PURPOSE
//  Parametrised successor of the 16-bit sample-to-double converter. Converts a W-bit two's-complement
//  audio sample into an IEEE-754 double over several clk_operation cycles, using a shift-and-count
//  normaliser. Sits between the sampled input path and the double-precision echo-cancellation datapath.
//  Adds integer/fractional (Q1.W-1) scaling, a busy flag and a one-cycle ready pulse.
// PARAMETERS
//  W          16  sample width in bits; legal range 2..53, so every conversion is exact (no rounding)
//  FRAC_MODE  0   0: value = signed integer; 1: value = sig_in / 2^(W-1), a Q1.(W-1) fraction
// PORTS
//  clk_operation  in   1   operation clock; all state changes on its rising edge
//  rst            in   1   asynchronous, active-high reset
//  enable         in   1   start request; sampled only in IDLE
//  sig_in         in   W   two's-complement sample, captured on the accepting edge
//  double         out  64  result {sign, exp[10:0], mant[51:0]}; holds until the next result
//  ready          out  1   one-cycle pulse: double is valid and newly updated
//  busy           out  1   high in NORM and PACK; enable is ignored while busy
// BEHAVIOUR
//  Reset (async, any state): state=IDLE, double=64'h0, ready=0, busy=0, internal mag/exp/sign cleared.
//  FSM states: IDLE -> NORM -> PACK -> IDLE.
//  IDLE: at an edge with enable=1: sign<=sig_in[W-1]; mag<=|sig_in| as W-bit unsigned
//   (-2^(W-1) gives 2^(W-1), no overflow); pos<=W-1; go to NORM. With enable=0, stay in IDLE.
//  NORM (one step per edge):
//   - if mag==0, set zero flag and go to PACK;
//   - else if mag[W-1]==1, go to PACK;
//   - else mag<=mag<<1 and pos<=pos-1.
//  PACK (one edge): write double, pulse ready for one cycle, return to IDLE.
//   - zero: double<=64'h0 (+0.0; a negative zero is never produced).
//   - otherwise: exp = 1023 + pos - (FRAC_MODE ? W-1 : 0).
//     mant = mag[W-2:0] left-aligned into bits [51:0], zero-filled below.
//     double = {sign, exp, mant}.
//  Timing: with enable accepted at edge k and lz = leading zeros of mag:
//   - ready is high in the cycle after edge k+2+lz;
//   - zero input gives ready after edge k+2;
//   - worst case (nonzero) is ready after edge k+W+1.
//  ready is combinationally independent of enable and is registered.
//   - The return to IDLE happens on the same edge that raises ready.
//   - So enable=1 during the ready cycle is accepted, allowing back-to-back conversions.
//  enable held high: a new conversion starts at every IDLE edge; there is no edge detect.
//  enable asserted while busy is dropped (not queued); sig_in changes during busy have no effect.
//  double is updated only in PACK; between results it holds its value.
//  Exponent width: pos fits in ceil(log2(W)) bits; exp is computed in 11 bits and never under- or overflows
//   for W<=53.
// TESTING (W=16 unless stated)
//  1) FRAC_MODE=0, sig_in=16'h0001, pulse enable
//     -> double=64'h3FF0000000000000, ready exactly 17 cycles after the accepting edge, busy high meanwhile.
//  2) sig_in=16'h8000 -> 64'hC0E0000000000000, latency 2;
//     sig_in=16'hFFFF -> 64'hBFF0000000000000;
//     sig_in=16'h7FFF -> 64'h40DFFFC000000000.
//  3) sig_in=16'h0000 -> double=64'h0, ready after 2 cycles;
//     then sig_in=16'h8000 with enable held through the ready cycle -> accepted with no idle gap.
//  4) FRAC_MODE=1: 16'h4000 -> 64'h3FE0000000000000; 16'h8000 -> 64'hBFF0000000000000;
//     16'h0001 -> 64'h3F00000000000000.
//  5) Pulse enable with 16'h0001, pulse enable again with 16'h7FFF at cycle 3
//     -> second request ignored; only the 1.0 result is produced; exactly one ready pulse.
//  6) Assert rst asynchronously mid-NORM -> double=0, ready=0, busy=0 immediately.
//     After release, a conversion of 16'hFFFF completes normally.
//  Also run a random sweep of 10k samples for W=16 and W=24 in both modes, checked against $itor/$realtobits.

Source files
------------

// File: rtl/sign_to_double_seq.sv
// sign_to_double_seq: multi-cycle W-bit two's-complement sample to IEEE-754 double converter
// Ports:
//   clk_operation - operation clock, all state changes on its rising edge
//   rst           - asynchronous active-high reset
//   enable        - start request, sampled only while idle
//   sig_in        - W-bit two's-complement sample, captured on the accepting edge
//   double        - 64-bit result {sign, exp, mant}, held until the next conversion completes
//   ready         - one-cycle pulse when double has just been updated
//   busy          - high while a conversion is in progress
module sign_to_double_seq #(
    parameter int W         = 16,
    parameter bit FRAC_MODE = 1'b0
) (
    input  logic         clk_operation,
    input  logic         rst,
    input  logic         enable,
    input  logic [W-1:0] sig_in,
    output logic [63:0]  double,
    output logic         ready,
    output logic         busy
);
    localparam int PW = $clog2(W);
    // Fraction mode divides by 2^(W-1), which only shifts the exponent bias
    localparam logic [10:0] BIAS = 11'(FRAC_MODE ? 1023 - (W - 1) : 1023);

    typedef enum logic [1:0] {IDLE, NORM, PACK} state_t;

    state_t        state, state_nxt;
    logic [W-1:0]  mag, mag_nxt;
    logic [PW-1:0] pos, pos_nxt;
    logic          sign, sign_nxt;
    logic          zero, zero_nxt;
    logic [63:0]   double_nxt;
    logic          ready_nxt;
    logic [W+50:0] mant_wide;
    logic [10:0]   exp_v;

    // Drop the implicit leading one and left-align the remaining bits into the 52-bit field
    assign mant_wide = {mag[W-2:0], 52'b0};
    assign exp_v     = BIAS + 11'(pos);
    assign busy      = state != IDLE;

    always_ff @(posedge clk_operation or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            mag    <= '0;
            pos    <= '0;
            sign   <= 1'b0;
            zero   <= 1'b0;
            double <= '0;
            ready  <= 1'b0;
        end else begin
            state  <= state_nxt;
            mag    <= mag_nxt;
            pos    <= pos_nxt;
            sign   <= sign_nxt;
            zero   <= zero_nxt;
            double <= double_nxt;
            ready  <= ready_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        mag_nxt    = mag;
        pos_nxt    = pos;
        sign_nxt   = sign;
        zero_nxt   = zero;
        double_nxt = double;
        ready_nxt  = 1'b0;
        case (state)
            IDLE: if (enable) begin
                state_nxt = NORM;
                sign_nxt  = sig_in[W-1];
                // W-bit unsigned magnitude: the most negative input maps to 2^(W-1)
                mag_nxt   = sig_in[W-1] ? -sig_in : sig_in;
                pos_nxt   = PW'(W - 1);
                zero_nxt  = 1'b0;
            end
            NORM: if (mag == '0) begin
                zero_nxt  = 1'b1;
                state_nxt = PACK;
            end else if (mag[W-1]) begin
                state_nxt = PACK;
            end else begin
                mag_nxt = mag << 1;
                pos_nxt = pos - PW'(1);
            end
            PACK: begin
                state_nxt  = IDLE;
                ready_nxt  = 1'b1;
                double_nxt = zero ? 64'h0 : {sign, exp_v, mant_wide[W+50 -: 52]};
            end
            default: state_nxt = IDLE;
        endcase
    end
endmodule

// File: tb/tb_sign_to_double_seq.sv
// tb_sign_to_double_seq: randomized self-checking bench for sign_to_double_seq
// Ports: none; drives four instances (W=16/24, FRAC_MODE=0/1) from a shared clock
module tb_sign_to_double_seq;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en[4];
    logic [23:0] sin[4];
    logic [63:0] dbl[4];
    logic        rdy[4];
    logic        bsy[4];
    int          n_tests = 0;
    int          n_fail = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 4; g++) begin : g_dut
        localparam int GW = g < 2 ? 16 : 24;
        sign_to_double_seq #(.W(GW), .FRAC_MODE(g % 2 == 1)) u_dut (
            .clk_operation(clk),
            .rst(rst),
            .enable(en[g]),
            .sig_in(sin[g][GW-1:0]),
            .double(dbl[g]),
            .ready(rdy[g]),
            .busy(bsy[g])
        );
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic int sext(input logic [23:0] s, input int w);
        int u;
        u = int'(s) & ((1 << w) - 1);
        return u >= (1 << (w - 1)) ? u - (1 << w) : u;
    endfunction

    function automatic logic [63:0] ref_double(input int v, input int w, input bit frac);
        real r;
        r = $itor(v);
        if (frac) r = r / $itor(1 << (w - 1));
        return $realtobits(r);
    endfunction

    // Latency = 2 + leading zeros of |v| within w bits; zero takes 2
    function automatic int ref_lat(input int v, input int w);
        int m;
        int lat;
        m = v < 0 ? -v : v;
        lat = 2;
        for (int b = 0; b < w; b++) if (m >= (1 << b)) lat = 2 + (w - 1 - b);
        return lat;
    endfunction

    task automatic conv(input int g, input logic [23:0] s, output logic [63:0] d, output int lat, output bit busy_ok);
        @(negedge clk);
        en[g]  = 1'b1;
        sin[g] = s;
        @(negedge clk);
        en[g]   = 1'b0;
        busy_ok = bsy[g];
        lat     = 0;
        do begin
            sin[g] = 24'($urandom);
            @(negedge clk);
            lat++;
            if (!rdy[g]) busy_ok &= bsy[g];
        end while (!rdy[g] && lat < 100);
        d = dbl[g];
    endtask

    task automatic sweep(input int g, input int n);
        int          w;
        bit          frac;
        logic [23:0] s;
        logic [63:0] d;
        int          v;
        int          lat;
        bit          ok;
        w    = g < 2 ? 16 : 24;
        frac = g[0];
        for (int i = 0; i < n; i++) begin
            s = 24'($urandom);
            if ($urandom_range(3) == 0) s = s >> $urandom_range(23);
            if ($urandom_range(31) == 0) s = 24'(1) << (w - 1);
            v = sext(s, w);
            conv(g, s, d, lat, ok);
            chk($sformatf("sweep%0d_val_%h", g, s), d, ref_double(v, w, frac));
            chk($sformatf("sweep%0d_lat_%h", g, s), 64'(lat), 64'(ref_lat(v, w)));
        end
    endtask

    initial begin
        logic [63:0] d;
        int          lat;
        bit          ok;
        int          pulses;
        for (int i = 0; i < 4; i++) begin
            en[i]  = 1'b0;
            sin[i] = '0;
        end
        repeat (3) @(negedge clk);
        chk("rst_double", dbl[0], 64'h0);
        chk("rst_ready", 64'(rdy[0]), 64'h0);
        chk("rst_busy", 64'(bsy[0]), 64'h0);
        rst = 1'b0;

        conv(0, 24'h0001, d, lat, ok);
        chk("one_val", d, 64'h3FF0000000000000);
        chk("one_lat", 64'(lat), 64'd17);
        chk("one_busy", 64'(ok), 64'd1);
        @(negedge clk);
        chk("one_ready_pulse", 64'(rdy[0]), 64'h0);
        chk("one_hold", dbl[0], 64'h3FF0000000000000);

        conv(0, 24'h8000, d, lat, ok);
        chk("min_val", d, 64'hC0E0000000000000);
        chk("min_lat", 64'(lat), 64'd2);
        conv(0, 24'hFFFF, d, lat, ok);
        chk("m1_val", d, 64'hBFF0000000000000);
        chk("m1_lat", 64'(lat), 64'd17);
        conv(0, 24'h7FFF, d, lat, ok);
        chk("max_val", d, 64'h40DFFFC000000000);
        chk("max_lat", 64'(lat), 64'd3);

        @(negedge clk);
        en[0]  = 1'b1;
        sin[0] = 24'h0000;
        @(negedge clk);
        chk("zero_busy", 64'(bsy[0]), 64'd1);
        @(negedge clk);
        chk("zero_early", 64'(rdy[0]), 64'd0);
        @(negedge clk);
        chk("zero_ready", 64'(rdy[0]), 64'd1);
        chk("zero_val", dbl[0], 64'h0);
        sin[0] = 24'h8000;
        @(negedge clk);
        chk("b2b_busy", 64'(bsy[0]), 64'd1);
        en[0] = 1'b0;
        @(negedge clk);
        chk("b2b_early", 64'(rdy[0]), 64'd0);
        @(negedge clk);
        chk("b2b_ready", 64'(rdy[0]), 64'd1);
        chk("b2b_val", dbl[0], 64'hC0E0000000000000);

        conv(1, 24'h4000, d, lat, ok);
        chk("frac_half", d, 64'h3FE0000000000000);
        conv(1, 24'h8000, d, lat, ok);
        chk("frac_m1", d, 64'hBFF0000000000000);
        conv(1, 24'h0001, d, lat, ok);
        chk("frac_lsb", d, 64'h3F00000000000000);
        chk("frac_lsb_lat", 64'(lat), 64'd17);

        @(negedge clk);
        en[0]  = 1'b1;
        sin[0] = 24'h0001;
        @(negedge clk);
        en[0]  = 1'b0;
        pulses = 0;
        d      = '0;
        for (int c = 0; c < 30; c++) begin
            if (c == 2) begin
                en[0]  = 1'b1;
                sin[0] = 24'h7FFF;
            end
            if (c == 3) en[0] = 1'b0;
            @(negedge clk);
            if (rdy[0]) begin
                pulses++;
                d = dbl[0];
            end
        end
        chk("drop_pulses", 64'(pulses), 64'd1);
        chk("drop_val", d, 64'h3FF0000000000000);

        @(negedge clk);
        en[0]  = 1'b1;
        sin[0] = 24'h0001;
        @(negedge clk);
        en[0] = 1'b0;
        repeat (4) @(negedge clk);
        chk("pre_rst_busy", 64'(bsy[0]), 64'd1);
        #2 rst = 1'b1;
        #1;
        chk("arst_double", dbl[0], 64'h0);
        chk("arst_ready", 64'(rdy[0]), 64'h0);
        chk("arst_busy", 64'(bsy[0]), 64'h0);
        @(negedge clk);
        rst = 1'b0;
        conv(0, 24'hFFFF, d, lat, ok);
        chk("post_rst_val", d, 64'hBFF0000000000000);
        chk("post_rst_lat", 64'(lat), 64'd17);

        fork
            sweep(0, 2500);
            sweep(1, 2500);
            sweep(2, 2500);
            sweep(3, 2500);
        join

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
